// File: rtl/instr_encoder_loader.sv
// Accepts decoded instruction tokens, packs them into RV32I words and writes them
// sequentially into instruction memory, holding the CPU in reset until a clean END.
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7_5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERROR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          err_q, err_d;

  logic signed [31:0]  simm;
  logic [31:0]         enc_word;
  logic [11:0]         imm_i;
  logic                range_ok;
  logic                is_write;
  logic                is_shift;
  logic                full;
  logic [1:0]          tok_err;

  assign simm     = $signed(in_imm);
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign is_write = (in_kind <= 3'd5);
  assign full     = (count_q == CNT_W'(DEPTH));

  always_comb begin
    enc_word = '0;
    range_ok = 1'b1;
    imm_i    = in_imm[11:0];
    if (in_funct3 == 3'b101) imm_i[11:5] = {1'b0, in_f7_5, 5'b0};
    case (in_kind)
      3'd0: enc_word = {in_f7_5 ? 7'h20 : 7'h00, in_rs2, in_rs1, in_funct3, in_rd, 7'h33};
      3'd1: begin
        enc_word = {imm_i, in_rs1, in_funct3, in_rd, 7'h13};
        range_ok = is_shift ? (simm >= 0 && simm <= 31)
                            : (simm >= -32'sd2048 && simm <= 32'sd2047);
      end
      3'd2: begin
        enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'h03};
        range_ok = (simm >= -32'sd2048 && simm <= 32'sd2047);
      end
      3'd3: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'h23};
        range_ok = (simm >= -32'sd2048 && simm <= 32'sd2047);
      end
      3'd4: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], 7'h63};
        range_ok = (simm >= -32'sd4096 && simm <= 32'sd4094) && !in_imm[0];
      end
      3'd5: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'h6F};
        range_ok = (simm >= -32'sd1048576 && simm <= 32'sd1048574) && !in_imm[0];
      end
      default: range_ok = 1'b1;
    endcase
  end

  // Reserved kind dominates, then overflow, then immediate range.
  always_comb begin
    tok_err = 2'd0;
    if (in_kind == 3'd7)         tok_err = 2'd3;
    else if (is_write && full)   tok_err = 2'd2;
    else if (is_write && !range_ok) tok_err = 2'd1;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = ACCEPT;
          addr_d  = '0;
          count_d = '0;
          err_d   = 2'd0;
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          if (tok_err != 2'd0) begin
            err_d   = tok_err;
            state_d = ERROR;
          end else if (in_kind == 3'd6) begin
            state_d = DONE;
          end else begin
            wdata_d = enc_word;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        count_d = count_q + 1'b1;
        state_d = ACCEPT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = (state_q == ACCEPT);
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (state_q != DONE);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERROR);
  assign err_code   = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: a default-size instance and a 4-word
// instance share token fields; a negedge monitor checks every memory write.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, in_valid, sel;
  logic [2:0]  kind, f3;
  logic        f75;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  logic        a_ready, a_we, a_hold, a_done, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [1:0]  a_code;
  logic [8:0]  a_count;
  logic        b_ready, b_we, b_hold, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [1:0]  b_code;
  logic [2:0]  b_count;

  logic rdy, m_done, m_err, m_hold, m_we;
  logic [1:0] m_code;
  logic [31:0] m_count;
  assign rdy     = sel ? b_ready : a_ready;
  assign m_we    = sel ? b_we    : a_we;
  assign m_done  = sel ? b_done  : a_done;
  assign m_err   = sel ? b_err   : a_err;
  assign m_hold  = sel ? b_hold  : a_hold;
  assign m_code  = sel ? b_code  : a_code;
  assign m_count = sel ? 32'(b_count) : 32'(a_count);

  instr_encoder_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start && !sel), .in_valid(in_valid && !sel),
    .in_ready(a_ready), .in_kind(kind), .in_funct3(f3), .in_f7_5(f75), .in_rd(rd),
    .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .imem_we(a_we), .imem_addr(a_addr),
    .imem_wdata(a_wdata), .cpu_hold(a_hold), .done(a_done), .error(a_err),
    .err_code(a_code), .count(a_count));

  instr_encoder_loader #(.ADDR_W(2)) dut_s (
    .clk(clk), .reset(reset), .start(start && sel), .in_valid(in_valid && sel),
    .in_ready(b_ready), .in_kind(kind), .in_funct3(f3), .in_f7_5(f75), .in_rd(rd),
    .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .imem_we(b_we), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .cpu_hold(b_hold), .done(b_done), .error(b_err),
    .err_code(b_code), .count(b_count));

  typedef struct { int addr; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_write(input int addr, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write", addr, data);
    end else begin
      e = sb.pop_front();
      $display("write addr=%0d data=0x%08h", addr, data);
      chk("write_addr", 32'(addr), 32'(e.addr));
      chk("write_data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (a_we) chk_write(int'(a_addr), a_wdata);
    if (b_we) chk_write(int'(b_addr), b_wdata);
  end

  // Reference encoder: fields placed by shift/mask arithmetic from the RV32I formats.
  task automatic ref_model(input logic [2:0] k, input logic [2:0] fn3, input logic f7,
                           input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [31:0] u, input bit is_full,
                           output logic [1:0] err, output logic [31:0] w);
    int v;
    bit ok;
    logic [31:0] immf;
    v = $signed(u);
    ok = 1'b1;
    w = 32'h0;
    case (k)
      3'd0: w = 32'h33 | (32'(d) << 7) | (32'(fn3) << 12) | (32'(s1) << 15) | (32'(s2) << 20)
                | ((f7 ? 32'h20 : 32'h0) << 25);
      3'd1: begin
        immf = u & 32'hFFF;
        if (fn3 == 3'd5) immf = (immf & 32'h1F) | (f7 ? 32'h400 : 32'h0);
        w = 32'h13 | (32'(d) << 7) | (32'(fn3) << 12) | (32'(s1) << 15) | (immf << 20);
        if (fn3 == 3'd1 || fn3 == 3'd5) ok = (v >= 0 && v <= 31);
        else ok = (v >= -2048 && v <= 2047);
      end
      3'd2: begin
        w = 32'h03 | (32'(d) << 7) | (32'd2 << 12) | (32'(s1) << 15) | ((u & 32'hFFF) << 20);
        ok = (v >= -2048 && v <= 2047);
      end
      3'd3: begin
        w = 32'h23 | ((u & 32'h1F) << 7) | (32'd2 << 12) | (32'(s1) << 15) | (32'(s2) << 20)
            | (((u >> 5) & 32'h7F) << 25);
        ok = (v >= -2048 && v <= 2047);
      end
      3'd4: begin
        w = 32'h63 | (((u >> 11) & 32'h1) << 7) | (((u >> 1) & 32'hF) << 8) | (32'(fn3) << 12)
            | (32'(s1) << 15) | (32'(s2) << 20) | (((u >> 5) & 32'h3F) << 25)
            | (((u >> 12) & 32'h1) << 31);
        ok = (v >= -4096 && v <= 4094) && (v % 2 == 0);
      end
      3'd5: begin
        w = 32'h6F | (32'(d) << 7) | (((u >> 12) & 32'hFF) << 12) | (((u >> 11) & 32'h1) << 20)
            | (((u >> 1) & 32'h3FF) << 21) | (((u >> 20) & 32'h1) << 31);
        ok = (v >= -1048576 && v <= 1048574) && (v % 2 == 0);
      end
      default: ok = 1'b1;
    endcase
    if (k == 3'd7) err = 2'd3;
    else if (k <= 3'd5 && is_full) err = 2'd2;
    else if (k <= 3'd5 && !ok) err = 2'd1;
    else err = 2'd0;
  endtask

  task automatic start_session(input logic s);
    @(negedge clk);
    sel = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    m_cnt = 0;
  endtask

  task automatic send_tok(input logic [2:0] k, input logic [2:0] fn3, input logic f7,
                          input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [31:0] im, input bit use_lit, input logic [31:0] lit,
                          output logic [1:0] err);
    int t;
    int dep;
    logic [31:0] w;
    t = 0;
    dep = sel ? 4 : 256;
    @(negedge clk);
    kind = k; f3 = fn3; f75 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    while (!rdy && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: got in_ready=0 for 10 cycles expected 1");
      in_valid = 1'b0;
      err = 2'd0;
      return;
    end
    ref_model(k, fn3, f7, d, s1, s2, im, m_cnt == dep, err, w);
    if (err == 2'd0 && k != 3'd6) begin
      sb.push_back('{m_cnt % dep, use_lit ? lit : w});
      m_cnt++;
    end
    $display("token kind=%0d f3=%0d imm=%0d -> expect err=%0d", k, fn3, $signed(im), err);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_status(input logic ed, input logic ee, input logic [1:0] ec,
                              input int cnt);
    @(negedge clk);
    chk("done", 32'(m_done), 32'(ed));
    chk("error", 32'(m_err), 32'(ee));
    chk("err_code", 32'(m_code), 32'(ec));
    chk("cpu_hold", 32'(m_hold), 32'(!ed));
    chk("count", m_count, 32'(cnt));
    chk("pending_writes", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [31:0] gen_imm(input logic [2:0] k, input logic [2:0] fn3, input bit bad);
    int v;
    v = int'($urandom);
    case (k)
      3'd1: if (fn3 == 3'd1 || fn3 == 3'd5)
              v = bad ? ($urandom_range(0, 1) ? 32 + int'($urandom_range(0, 99)) : -1 - int'($urandom_range(0, 99)))
                      : int'($urandom_range(0, 31));
            else
              v = bad ? 2048 + int'($urandom_range(0, 999)) : int'($urandom_range(0, 4095)) - 2048;
      3'd2, 3'd3:
        v = bad ? -2049 - int'($urandom_range(0, 999)) : int'($urandom_range(0, 4095)) - 2048;
      3'd4: v = bad ? (2 * int'($urandom_range(0, 100)) + 1) : 2 * (int'($urandom_range(0, 4095)) - 2048);
      3'd5: v = bad ? 1048576 : 2 * (int'($urandom_range(0, 1048575)) - 524288);
      default: v = int'($urandom);
    endcase
    return 32'(v);
  endfunction

  initial begin
    logic [1:0] e;
    int r;
    int n;
    bit ended;
    bit bad;
    logic [2:0] k;
    logic [2:0] fn;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; sel = 1'b0;
    kind = '0; f3 = '0; f75 = 1'b0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_we", 32'(a_we), 32'd0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_wdata", a_wdata, 32'd0);
    chk("rst_hold", 32'(a_hold), 32'd1);
    chk("rst_done_err", 32'({a_done, a_err, a_code}), 32'd0);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_small_hold", 32'(b_hold), 32'd1);
    reset = 1'b0;

    // Directed program with known encodings.
    start_session(1'b0);
    send_tok(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, e);
    send_tok(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3, e);
    send_tok(3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd10, 1'b1, 32'h00A00293, e);
    send_tok(3'd2, 3'd2, 1'b0, 5'd6, 5'd5, 5'd0, 32'd4, 1'b1, 32'h0042A303, e);
    send_tok(3'd3, 3'd2, 1'b0, 5'd0, 5'd0, 5'd6, 32'd8, 1'b1, 32'h00602423, e);
    send_tok(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 32'hFE208CE3, e);
    send_tok(3'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0, e);
    check_status(1'b1, 1'b0, 2'd0, 6);

    start_session(1'b0);
    send_tok(3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd2048, 1'b0, 32'd0, e);
    check_status(1'b0, 1'b1, 2'd1, 0);

    start_session(1'b0);
    send_tok(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd6, 1'b0, 32'd0, e);
    send_tok(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7, 1'b0, 32'd0, e);
    check_status(1'b0, 1'b1, 2'd1, 1);

    // in_valid held high: ready alternates, writes land at 0,1,2.
    start_session(1'b0);
    kind = 3'd1; f3 = 3'd0; f75 = 1'b0; rd = 5'd7; rs1 = 5'd1; rs2 = 5'd0; imm = 32'd33;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ready_pulse", 32'(a_ready), 32'(i % 2 == 0));
      if (a_ready) begin
        logic [31:0] w;
        ref_model(kind, f3, f75, rd, rs1, rs2, imm, 1'b0, e, w);
        sb.push_back('{m_cnt, w});
        m_cnt++;
      end
    end
    in_valid = 1'b0;
    send_tok(3'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0, e);
    check_status(1'b1, 1'b0, 2'd0, 3);

    // Reset asserted during WRITE.
    start_session(1'b0);
    send_tok(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'd0, e);
    @(negedge clk);
    chk("we_in_write", 32'(a_we), 32'd1);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_we", 32'(a_we), 32'd0);
    chk("rst_mid_count", 32'(a_count), 32'd0);
    chk("rst_mid_hold", 32'(a_hold), 32'd1);
    chk("rst_mid_ready", 32'(a_ready), 32'd0);
    start_session(1'b0);
    send_tok(3'd0, 3'd7, 1'b0, 5'd9, 5'd8, 5'd7, 32'd0, 1'b0, 32'd0, e);
    send_tok(3'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0, e);
    check_status(1'b1, 1'b0, 2'd0, 1);

    // 4-word instance: overflow, then END exactly at capacity.
    start_session(1'b1);
    for (int i = 0; i < 4; i++)
      send_tok(3'd1, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0, 32'd0, e);
    send_tok(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'd0, e);
    check_status(1'b0, 1'b1, 2'd2, 4);
    start_session(1'b1);
    for (int i = 0; i < 4; i++)
      send_tok(3'd3, 3'd2, 1'b0, 5'd0, 5'(i), 5'(i + 4), 32'(i * 4 - 8), 1'b0, 32'd0, e);
    send_tok(3'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0, e);
    check_status(1'b1, 1'b0, 2'd0, 4);

    // Randomized sessions on the default-size instance.
    for (int s = 0; s < 8; s++) begin
      start_session(1'b0);
      n = int'($urandom_range(1, 12));
      ended = 1'b0;
      for (int t = 0; t < n && !ended; t++) begin
        r = int'($urandom_range(0, 19));
        k = (r < 18) ? 3'(r % 6) : ((r == 18) ? 3'd7 : 3'd6);
        fn = 3'($urandom_range(0, 7));
        bad = ($urandom_range(0, 9) == 0);
        send_tok(k, fn, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 gen_imm(k, fn, bad), 1'b0, 32'd0, e);
        if (e != 2'd0) begin
          check_status(1'b0, 1'b1, e, m_cnt);
          ended = 1'b1;
        end else if (k == 3'd6) begin
          check_status(1'b1, 1'b0, 2'd0, m_cnt);
          ended = 1'b1;
        end
      end
      if (!ended) begin
        send_tok(3'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0, e);
        check_status(1'b1, 1'b0, 2'd0, m_cnt);
      end
    end

    repeat (3) @(negedge clk);
    chk("final_pending", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
